alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Stage directly downstream of the ALU in the single-IPC core.
- Accepts one ALU result per handshake and evaluates the instruction's store condition against that result's flags.
- Commits the architectural flags register (carry, overflow, zero, negative) and queues the write toward the register-file/memory write port through a 2-entry skid buffer.
- Drives the registered carry back to the ALU carry_in.

Parameters:
- DATA_WIDTH, 16, result/write data width
- ADDR_WIDTH, 16, destination address width

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents an ALU result
- in_ready  output  1  stage can accept this cycle
- in_result  input  DATA_WIDTH  ALU result
- in_carry  input  1  ALU carry out
- in_overflow  input  1  ALU overflow out
- in_zero  input  1  ALU zero out
- in_negative  input  1  ALU negative out
- in_cond  input  3  store condition code
- in_update_flags  input  1  commit flags on accept
- in_dest_mem  input  1  1 = memory destination, 0 = register destination
- in_dest_addr  input  ADDR_WIDTH  destination address/register index
- flags_load  input  1  overwrite flags register (interrupt return)
- flags_load_value  input  4  {C,O,Z,N} value to load
- wr_valid  output  1  write pending
- wr_ready  input  1  write port accepts
- wr_data  output  DATA_WIDTH  write data
- wr_addr  output  ADDR_WIDTH  write address
- wr_mem  output  1  write targets memory
- flags  output  4  {C,O,Z,N} architectural flags
- carry_to_alu  output  1  equals flags[3]
- suppressed  output  1  one-cycle pulse: an accepted op had its store dropped

Behaviour:
- Reset: all of the following are 0 on the cycle after reset is high: flags, both buffer entries, wr_valid, wr_data, wr_addr, wr_mem, suppressed. in_ready is 1 after reset.
  - Reset mid-operation discards queued writes, with no partial write.
  - Reset has priority over all other inputs.
- Accept condition: in_valid & in_ready.
- in_ready = ~skid_valid. It is registered-state-derived and never combinationally dependent on wr_ready.
- Condition is evaluated on the incoming in_* flags, not on the registered flags:
  - 0 always
  - 1 Z
  - 2 ~Z
  - 3 N
  - 4 ~N & ~Z
  - 5 O
  - 6 C
  - 7 never
- Condition true on accept: the entry {data, addr, mem} is enqueued.
- Condition false on accept: nothing is enqueued and suppressed pulses for 1 cycle.
- Flags on accept with in_update_flags = 1: flags <= {in_carry, in_overflow, in_zero, in_negative}, regardless of the condition result.
- flags_load has priority over an accept-cycle flag update in the same cycle. The accepted op's write is still enqueued.
- Skid buffer:
  - Entries are main (drives wr_*) and skid. States: EMPTY, ONE (main valid), FULL (main and skid valid).
  - EMPTY + enqueue -> ONE. wr_valid asserts the next cycle (latency 1).
  - ONE + enqueue + wr_ready -> ONE, main replaced.
  - ONE + enqueue + ~wr_ready -> FULL, new entry goes to skid.
  - ONE + wr_ready with no enqueue -> EMPTY.
  - FULL + wr_ready -> ONE, skid moves to main.
  - No enqueue is possible in FULL, because in_ready = 0.
- Ordering: writes leave strictly in accept order. No entry is ever dropped or duplicated.
- wr_* outputs hold stable while wr_valid & ~wr_ready.
- A suppressed op is accepted even while ONE with ~wr_ready. It does not consume a slot.
- carry_to_alu is registered only, with no bypass. The upstream stage is responsible for not issuing a carry-dependent op in the cycle right after its producer.

Decomposition:
- Shared package alu_defs:
  - COND_* codes (3-bit)
  - flag bit indices: FLAG_C = 3, FLAG_O = 2, FLAG_Z = 1, FLAG_N = 0
  - DATA_WIDTH/ADDR_WIDTH defaults
- One sub-module, skid_buffer_2: generic 2-entry valid/ready buffer with payload width = DATA_WIDTH + ADDR_WIDTH + 1.
- Condition decode and the flags register stay in the top module.

Test Plan:
- Reset then idle -> flags = 0, wr_valid = 0, in_ready = 1, carry_to_alu = 0.
- Accept result 0x1234, cond 0, addr 0x0005, update_flags = 1, C=1, others 0, wr_ready = 1 -> next cycle wr_valid = 1, wr_data = 0x1234, wr_addr = 0x0005; flags = 4'b1000; carry_to_alu = 1.
- Accept cond 1 (Z) with in_zero = 0, update_flags = 1, N = 1 -> no wr_valid; suppressed pulses 1 cycle; flags = 4'b0001.
- Hold wr_ready = 0 and send 0xAAAA then 0xBBBB -> in_ready falls after the second accept; a third op is held off; releasing wr_ready drains 0xAAAA then 0xBBBB in order, with wr_data stable while stalled.
- flags_load = 1 with value 4'b0110 in the same cycle as an accept with update_flags = 1 and C=1 -> flags = 4'b0110; the accepted write still appears.
- Reset asserted while FULL -> next cycle wr_valid = 0, in_ready = 1, flags = 0; no stale write is emitted after reset deasserts.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: condition codes, flag
// bit positions, default widths and the skid buffer state encoding.
package alu_defs;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 16;

  // Bit positions inside the {C,O,Z,N} flags vector
  localparam int FLAG_C = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_N      = 3'd3,
    COND_GT     = 3'd4,
    COND_O      = 3'd5,
    COND_C      = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_writeback_if.sv
// Bus bundle between the ALU, the writeback stage and the write port.
// slave is the writeback stage's view; master is the surrounding pipeline.
interface alu_writeback_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  in_carry;
  logic                  in_overflow;
  logic                  in_zero;
  logic                  in_negative;
  logic [2:0]            in_cond;
  logic                  in_update_flags;
  logic                  in_dest_mem;
  logic [ADDR_WIDTH-1:0] in_dest_addr;
  logic                  flags_load;
  logic [3:0]            flags_load_value;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_mem;
  logic [3:0]            flags;
  logic                  carry_to_alu;
  logic                  suppressed;

  modport slave (
    input  in_valid, in_result, in_carry, in_overflow, in_zero, in_negative,
           in_cond, in_update_flags, in_dest_mem, in_dest_addr,
           flags_load, flags_load_value, wr_ready,
    output in_ready, wr_valid, wr_data, wr_addr, wr_mem, flags,
           carry_to_alu, suppressed
  );

  modport master (
    output in_valid, in_result, in_carry, in_overflow, in_zero, in_negative,
           in_cond, in_update_flags, in_dest_mem, in_dest_addr,
           flags_load, flags_load_value, wr_ready,
    input  in_ready, wr_valid, wr_data, wr_addr, wr_mem, flags,
           carry_to_alu, suppressed
  );

endinterface

// File: rtl/alu_writeback_skid.sv
// Two-entry valid/ready buffer; main drives the output, skid catches one
// extra entry while the consumer stalls.
//   state     | meaning
//   BUF_EMPTY | nothing queued
//   BUF_ONE   | main valid
//   BUF_FULL  | main and skid valid, upstream blocked
module skid_buffer_2
  import alu_defs::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data
);

  buf_state_e       state_q, state_next;
  logic [WIDTH-1:0] main_q, main_next;
  logic [WIDTH-1:0] skid_q, skid_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_next;
      main_q  <= main_next;
      skid_q  <= skid_next;
    end
  end

  always_comb begin
    state_next = state_q;
    main_next  = main_q;
    skid_next  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (enq_valid) begin
          state_next = BUF_ONE;
          main_next  = enq_data;
        end
      end
      BUF_ONE: begin
        if (enq_valid && deq_ready) begin
          main_next = enq_data;
        end else if (enq_valid) begin
          state_next = BUF_FULL;
          skid_next  = enq_data;
        end else if (deq_ready) begin
          state_next = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // enq_ready is low here, so only a drain can happen
        if (deq_ready) begin
          state_next = BUF_ONE;
          main_next  = skid_q;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  assign enq_ready = (state_q != BUF_FULL);
  assign deq_valid = (state_q != BUF_EMPTY);
  assign deq_data  = main_q;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: evaluates the store condition on the incoming flags,
// commits the architectural flags and queues writes through a 2-entry buffer.
module alu_writeback
  import alu_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic          clock,
  input logic          reset,
  alu_writeback_if.slave bus
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;

  logic                     accept;
  logic                     cond_true;
  logic                     enq_valid;
  logic                     enq_ready;
  logic [PAYLOAD_WIDTH-1:0] enq_payload;
  logic [PAYLOAD_WIDTH-1:0] deq_payload;
  logic [3:0]               flags_q;
  logic                     suppressed_q;

  // Condition looks at the result's own flags, not the committed ones
  always_comb begin
    cond_true = 1'b0;
    case (bus.in_cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = bus.in_zero;
      COND_NZ:     cond_true = ~bus.in_zero;
      COND_N:      cond_true = bus.in_negative;
      COND_GT:     cond_true = ~bus.in_negative & ~bus.in_zero;
      COND_O:      cond_true = bus.in_overflow;
      COND_C:      cond_true = bus.in_carry;
      COND_NEVER:  cond_true = 1'b0;
      default:     cond_true = 1'b0;
    endcase
  end

  assign accept      = bus.in_valid & enq_ready;
  assign enq_valid   = accept & cond_true;
  assign enq_payload = {bus.in_result, bus.in_dest_addr, bus.in_dest_mem};

  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q      <= 4'b0000;
      suppressed_q <= 1'b0;
    end else begin
      suppressed_q <= accept & ~cond_true;
      if (bus.flags_load) begin
        flags_q <= bus.flags_load_value;
      end else if (accept && bus.in_update_flags) begin
        flags_q <= {bus.in_carry, bus.in_overflow, bus.in_zero, bus.in_negative};
      end
    end
  end

  skid_buffer_2 #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_payload),
    .deq_valid (bus.wr_valid),
    .deq_ready (bus.wr_ready),
    .deq_data  (deq_payload)
  );

  assign bus.in_ready     = enq_ready;
  assign {bus.wr_data, bus.wr_addr, bus.wr_mem} = deq_payload;
  assign bus.flags        = flags_q;
  assign bus.carry_to_alu = flags_q[FLAG_C];
  assign bus.suppressed   = suppressed_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  alu_writeback_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  alu_writeback #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid         = 1'b0;
    bus.in_carry         = 1'b0;
    bus.in_overflow      = 1'b0;
    bus.in_zero          = 1'b0;
    bus.in_negative      = 1'b0;
    bus.in_cond          = 3'd0;
    bus.in_update_flags  = 1'b0;
    bus.in_dest_mem      = 1'b0;
    bus.flags_load       = 1'b0;
    bus.flags_load_value = 4'b0000;
  endtask

  task automatic send(input logic [15:0] data, input logic [15:0] addr,
                      input logic mem, input logic [2:0] cond);
    bus.in_valid     = 1'b1;
    bus.in_result    = data;
    bus.in_dest_addr = addr;
    bus.in_dest_mem  = mem;
    bus.in_cond      = cond;
  endtask

  task automatic test_reset();
    clear_in();
    bus.in_result    = 16'h0;
    bus.in_dest_addr = 16'h0;
    bus.wr_ready     = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_tests++; if (bus.flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", bus.flags); end
    n_tests++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got %b want 0", bus.wr_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_tests++; if (bus.carry_to_alu !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", bus.carry_to_alu); end
    n_tests++; if (bus.wr_data !== 16'h0 || bus.wr_addr !== 16'h0 || bus.wr_mem !== 1'b0) begin n_fail++; $display("FAIL reset_wr_bus got %h/%h/%b want 0", bus.wr_data, bus.wr_addr, bus.wr_mem); end
    n_tests++; if (bus.suppressed !== 1'b0) begin n_fail++; $display("FAIL reset_suppressed got %b want 0", bus.suppressed); end
  endtask

  task automatic test_basic();
    bus.wr_ready = 1'b1;
    send(16'h1234, 16'h0005, 1'b0, 3'd0);
    bus.in_update_flags = 1'b1;
    bus.in_carry        = 1'b1;
    step();
    clear_in();
    n_tests++; if (bus.wr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_wr_valid got %b want 1", bus.wr_valid); end
    n_tests++; if (bus.wr_data !== 16'h1234) begin n_fail++; $display("FAIL basic_wr_data got %h want 1234", bus.wr_data); end
    n_tests++; if (bus.wr_addr !== 16'h0005) begin n_fail++; $display("FAIL basic_wr_addr got %h want 0005", bus.wr_addr); end
    n_tests++; if (bus.flags !== 4'b1000) begin n_fail++; $display("FAIL basic_flags got %b want 1000", bus.flags); end
    n_tests++; if (bus.carry_to_alu !== 1'b1) begin n_fail++; $display("FAIL basic_carry got %b want 1", bus.carry_to_alu); end
    n_tests++; if (bus.suppressed !== 1'b0) begin n_fail++; $display("FAIL basic_suppressed got %b want 0", bus.suppressed); end
    step();
    n_tests++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b want 0", bus.wr_valid); end
  endtask

  task automatic test_suppress();
    bus.wr_ready = 1'b1;
    send(16'h7777, 16'h0009, 1'b0, 3'd1);
    bus.in_update_flags = 1'b1;
    bus.in_negative     = 1'b1;
    step();
    clear_in();
    n_tests++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL supp_wr_valid got %b want 0", bus.wr_valid); end
    n_tests++; if (bus.suppressed !== 1'b1) begin n_fail++; $display("FAIL supp_pulse got %b want 1", bus.suppressed); end
    n_tests++; if (bus.flags !== 4'b0001) begin n_fail++; $display("FAIL supp_flags got %b want 0001", bus.flags); end
    n_tests++; if (bus.carry_to_alu !== 1'b0) begin n_fail++; $display("FAIL supp_carry got %b want 0", bus.carry_to_alu); end
    step();
    n_tests++; if (bus.suppressed !== 1'b0) begin n_fail++; $display("FAIL supp_pulse_end got %b want 0", bus.suppressed); end
  endtask

  task automatic test_back_to_back();
    bus.wr_ready = 1'b0;
    send(16'hAAAA, 16'h0010, 1'b1, 3'd0);
    step();
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one got %b want 1", bus.in_ready); end
    n_tests++; if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'hAAAA) begin n_fail++; $display("FAIL b2b_first got %b/%h want 1/aaaa", bus.wr_valid, bus.wr_data); end
    send(16'hBBBB, 16'h0011, 1'b0, 3'd0);
    step();
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full got %b want 0", bus.in_ready); end
    n_tests++; if (bus.wr_data !== 16'hAAAA) begin n_fail++; $display("FAIL b2b_hold1 got %h want aaaa", bus.wr_data); end
    send(16'hCCCC, 16'h0012, 1'b0, 3'd0);
    step();
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_third_held got %b want 0", bus.in_ready); end
    n_tests++; if (bus.wr_data !== 16'hAAAA || bus.wr_addr !== 16'h0010 || bus.wr_mem !== 1'b1) begin n_fail++; $display("FAIL b2b_hold2 got %h/%h/%b want aaaa/0010/1", bus.wr_data, bus.wr_addr, bus.wr_mem); end
    bus.wr_ready = 1'b1;
    step();
    n_tests++; if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'hBBBB || bus.wr_addr !== 16'h0011) begin n_fail++; $display("FAIL b2b_second got %b/%h/%h want 1/bbbb/0011", bus.wr_valid, bus.wr_data, bus.wr_addr); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back got %b want 1", bus.in_ready); end
    step();
    clear_in();
    n_tests++; if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'hCCCC) begin n_fail++; $display("FAIL b2b_third got %b/%h want 1/cccc", bus.wr_valid, bus.wr_data); end
    step();
    n_tests++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup got %b want 0", bus.wr_valid); end
  endtask

  task automatic test_suppress_stalled();
    bus.wr_ready = 1'b0;
    send(16'hDDDD, 16'h0013, 1'b0, 3'd0);
    step();
    send(16'hEEEE, 16'h0014, 1'b0, 3'd7);
    step();
    clear_in();
    n_tests++; if (bus.suppressed !== 1'b1) begin n_fail++; $display("FAIL stall_supp_pulse got %b want 1", bus.suppressed); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_supp_slot got %b want 1", bus.in_ready); end
    n_tests++; if (bus.wr_data !== 16'hDDDD) begin n_fail++; $display("FAIL stall_supp_data got %h want dddd", bus.wr_data); end
    bus.wr_ready = 1'b1;
    step();
    n_tests++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_supp_drain got %b want 0", bus.wr_valid); end
  endtask

  task automatic test_flags_load();
    bus.wr_ready = 1'b1;
    send(16'h5A5A, 16'h0020, 1'b1, 3'd6);
    bus.in_update_flags  = 1'b1;
    bus.in_carry         = 1'b1;
    bus.flags_load       = 1'b1;
    bus.flags_load_value = 4'b0110;
    step();
    clear_in();
    n_tests++; if (bus.flags !== 4'b0110) begin n_fail++; $display("FAIL fload_flags got %b want 0110", bus.flags); end
    n_tests++; if (bus.carry_to_alu !== 1'b0) begin n_fail++; $display("FAIL fload_carry got %b want 0", bus.carry_to_alu); end
    n_tests++; if (bus.wr_valid !== 1'b1 || bus.wr_data !== 16'h5A5A || bus.wr_mem !== 1'b1) begin n_fail++; $display("FAIL fload_write got %b/%h/%b want 1/5a5a/1", bus.wr_valid, bus.wr_data, bus.wr_mem); end
    step();
  endtask

  task automatic test_conditions();
    logic [3:0] pat  [3];
    logic [7:0] take [3];
    logic       exp;
    pat[0] = 4'b0101; take[0] = 8'b0010_1101;
    pat[1] = 4'b1010; take[1] = 8'b0100_0011;
    pat[2] = 4'b0000; take[2] = 8'b0001_0101;
    bus.wr_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 8; c++) begin
        send({8'hC0, 4'(p), 4'(c)}, 16'(c), 1'b0, 3'(c));
        {bus.in_carry, bus.in_overflow, bus.in_zero, bus.in_negative} = pat[p];
        step();
        clear_in();
        exp = take[p][c];
        n_tests++; if (bus.wr_valid !== exp) begin n_fail++; $display("FAIL cond_p%0d_c%0d_valid got %b want %b", p, c, bus.wr_valid, exp); end
        n_tests++; if (bus.suppressed !== ~exp) begin n_fail++; $display("FAIL cond_p%0d_c%0d_supp got %b want %b", p, c, bus.suppressed, ~exp); end
        if (exp) begin
          n_tests++; if (bus.wr_data !== {8'hC0, 4'(p), 4'(c)}) begin n_fail++; $display("FAIL cond_p%0d_c%0d_data got %h", p, c, bus.wr_data); end
        end
        n_tests++; if (bus.flags !== 4'b0110) begin n_fail++; $display("FAIL cond_p%0d_c%0d_flags got %b want 0110", p, c, bus.flags); end
        step();
      end
    end
  endtask

  task automatic test_reset_full();
    bus.wr_ready = 1'b0;
    send(16'h1111, 16'h0030, 1'b0, 3'd0);
    bus.in_update_flags = 1'b1;
    bus.in_carry        = 1'b1;
    step();
    bus.in_update_flags = 1'b0;
    bus.in_carry        = 1'b0;
    send(16'h2222, 16'h0031, 1'b0, 3'd0);
    step();
    n_tests++; if (bus.in_ready !== 1'b0 || bus.flags !== 4'b1000) begin n_fail++; $display("FAIL rstfull_setup got %b/%b want 0/1000", bus.in_ready, bus.flags); end
    send(16'h3333, 16'h0032, 1'b0, 3'd0);
    bus.flags_load       = 1'b1;
    bus.flags_load_value = 4'b1111;
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_in();
    n_tests++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_wr_valid got %b want 0", bus.wr_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull_in_ready got %b want 1", bus.in_ready); end
    n_tests++; if (bus.flags !== 4'b0000) begin n_fail++; $display("FAIL rstfull_flags got %b want 0000", bus.flags); end
    n_tests++; if (bus.wr_data !== 16'h0) begin n_fail++; $display("FAIL rstfull_wr_data got %h want 0000", bus.wr_data); end
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_stale_%0d got %b want 0", i, bus.wr_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_suppress();
    test_back_to_back();
    test_suppress_stalled();
    test_flags_load();
    test_conditions();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
